// File: rtl/column_shifter_pkg.sv
// Shared constants, control-bundle type and counter sizing for the LED column shifter.
package column_shifter_pkg;

  localparam int LANES_DEF = 8;
  localparam int WIDTH_DEF = 16;

  // Upstream sequencer strobes, load in the MSB position
  typedef struct packed {
    logic load;
    logic shift;
    logic sclk;
    logic oe_n;
    logic le;
  } ctrl_t;

  // sclk edge counter must be able to hold WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/column_shifter_if.sv
// Column-word valid/ready stream between the pattern sequencer and the shifter.
interface column_shifter_if
  import column_shifter_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic                     data_valid;
  logic                     data_ready;
  logic [LANES*WIDTH-1:0]   data_in;

  modport master (output data_valid, output data_in, input data_ready);
  modport slave  (input data_valid, input data_in, output data_ready);

endinterface

// File: rtl/column_shifter_lane_shreg.sv
// One lane: WIDTH-bit parallel-load shift register, MSB first, zero fill. Load beats shift.
module lane_shreg
  import column_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_r;

  // Load or advance the lane register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_r <= '0;
    end else if (load) begin
      shreg_r <= din;
    end else if (shift) begin
      shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign msb = shreg_r[WIDTH-1];

endmodule

// File: rtl/column_shifter.sv
// LED driver column shifter: staging buffer, LANES parallel serial lanes, pin retiming and frame checks.
// Build option: COLUMN_SHIFTER_REPEAT_EN repeats the last good word on underrun instead of blanking.
module column_shifter
  import column_shifter_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_in,
  input  logic              shift_in,
  input  logic              sclk_in,
  input  logic              oe_n_in,
  input  logic              le_in,
  column_shifter_if.slave   col_if,
  output logic [LANES-1:0]  sdi,
  output logic              sclk,
  output logic              oe_n,
  output logic              le,
  output logic              underrun,
  output logic              misalign
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_MAX  = '1;
  localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  ctrl_t                    ctrl_s;
  logic                     stage_full_r;
  logic [LANES*WIDTH-1:0]   stage_data_r;
  logic                     shift_d_r;
  logic                     sclk_r;
  logic                     le_r;
  logic                     oe_n_r;
  logic                     blank_r;
  logic                     underrun_r;
  logic                     misalign_r;
  logic [CW-1:0]            cnt_r;
`ifdef COLUMN_SHIFTER_REPEAT_EN
  logic [LANES*WIDTH-1:0]   last_word_r;
`endif

  logic                     data_ready_s;
  logic                     accept_s;
  logic                     good_load_s;
  logic                     under_load_s;
  logic                     blank_nxt_s;
  logic                     sclk_rise_s;
  logic                     le_rise_s;
  logic [LANES*WIDTH-1:0]   load_word_s;

  assign ctrl_s = {load_in, shift_in, sclk_in, oe_n_in, le_in};

  // Handshake, load classification, edge detection and the word presented to the lanes
  always_comb begin
    data_ready_s = ~stage_full_r | ctrl_s.load;
    accept_s     = col_if.data_valid & data_ready_s;
    good_load_s  = ctrl_s.load & stage_full_r;
    under_load_s = ctrl_s.load & ~stage_full_r;
    sclk_rise_s  = ctrl_s.sclk & ~sclk_r;
    le_rise_s    = ctrl_s.le & ~le_r;
    load_word_s  = '0;
    blank_nxt_s  = blank_r;
    if (stage_full_r) begin
      load_word_s = stage_data_r;
    end else begin
`ifdef COLUMN_SHIFTER_REPEAT_EN
      load_word_s = last_word_r;
`else
      load_word_s = '0;
`endif
    end
    if (good_load_s) begin
      blank_nxt_s = 1'b0;
    end else if (under_load_s) begin
`ifdef COLUMN_SHIFTER_REPEAT_EN
      blank_nxt_s = blank_r;
`else
      blank_nxt_s = 1'b1;
`endif
    end else begin
      blank_nxt_s = blank_r;
    end
  end

  // One-entry staging buffer; a same-cycle accept during load refills it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_full_r <= 1'b0;
      stage_data_r <= '0;
    end else if (accept_s) begin
      stage_full_r <= 1'b1;
      stage_data_r <= col_if.data_in;
    end else if (ctrl_s.load) begin
      stage_full_r <= 1'b0;
    end
  end

`ifdef COLUMN_SHIFTER_REPEAT_EN
  // Remember the last word that really came from staging
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_word_r <= '0;
    end else if (good_load_s) begin
      last_word_r <= stage_data_r;
    end
  end
`endif

  // Driver pin retiming, blanking and underrun pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_d_r  <= 1'b0;
      sclk_r     <= 1'b0;
      le_r       <= 1'b0;
      oe_n_r     <= 1'b1;
      blank_r    <= 1'b1;
      underrun_r <= 1'b0;
    end else begin
      shift_d_r  <= ctrl_s.shift;
      sclk_r     <= ctrl_s.sclk;
      le_r       <= ctrl_s.le;
      oe_n_r     <= ctrl_s.oe_n | blank_nxt_s;
      blank_r    <= blank_nxt_s;
      underrun_r <= under_load_s;
    end
  end

  // Count sclk rises since the last load; a latch with a short or long frame is sticky
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r      <= '0;
      misalign_r <= 1'b0;
    end else begin
      if (ctrl_s.load) begin
        cnt_r <= '0;
      end else if (sclk_rise_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (le_rise_s && (cnt_r != CNT_FULL)) begin
        misalign_r <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_shreg #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (ctrl_s.load),
      .shift   (shift_d_r),
      .din     (load_word_s[g*WIDTH +: WIDTH]),
      .msb     (sdi[g])
    );
  end

  assign col_if.data_ready = data_ready_s;
  assign sclk     = sclk_r;
  assign le       = le_r;
  assign oe_n     = oe_n_r;
  assign underrun = underrun_r;
  assign misalign = misalign_r;

endmodule

// File: doc/column_shifter.md
COLUMN_SHIFTER -- requirements
Module: column_shifter

Interface
- REQ-001 SHALL have parameter LANES, default 8: number of parallel serial-data lanes, one per LED driver chain.
- REQ-002 SHALL have parameter WIDTH, default 16: bits per lane per column word.
- REQ-003 SHALL have `clk  in  1`: the clock.
- REQ-004 SHALL have `reset_n  in  1`: reset, asynchronous, active-low.
- REQ-005 SHALL have `load_in, shift_in, sclk_in, oe_n_in, le_in  in  1 each`: registered control strobes from the upstream pattern sequencer.
- REQ-006 SHALL have `data_valid  in  1`: the upstream column word is valid.
- REQ-007 SHALL have `data_in  in  LANES*WIDTH`: column word; lane i occupies bits [i*WIDTH +: WIDTH].
- REQ-008 SHALL have `data_ready  out  1`: the block can accept a word.
- REQ-009 SHALL have `sdi  out  LANES`: serial data to the drivers; each lane outputs its MSB first.
- REQ-010 SHALL have `sclk, oe_n, le  out  1 each`: driver pins.
- REQ-011 SHALL have `underrun  out  1`: one-cycle pulse when a load finds no word staged.
- REQ-012 SHALL have `misalign  out  1`: sticky error, cleared only by reset.

Function
- REQ-013 SHALL hold a one-entry staging buffer; data_ready = staging empty OR load_in this cycle.
- REQ-014 SHALL accept a word into staging on a cycle where data_valid and data_ready are both high.
- REQ-015 On load_in with staging full: SHALL copy staging to the lane shift registers and mark staging empty.
  - An accept in the same cycle refills staging with the new word.
- REQ-016 On load_in with staging empty: SHALL pulse underrun for 1 cycle and load the lane registers per REQ-029.
- REQ-017 SHALL register shift_in into shift_d and advance all lane registers by one bit on cycles where shift_d=1.
  - Consequence: sdi changes one cycle after the sclk rising edge.
- REQ-018 sdi[i] SHALL equal the MSB of lane register i at all times, with no extra register stage.
- REQ-019 sclk, le and oe_n SHALL be the respective inputs delayed by exactly 1 clock.
- REQ-020 oe_n SHALL be additionally forced high while the blank flag is set.
- REQ-021 The blank flag SHALL be set by an underrun load when REPEAT is disabled, and cleared by the next successful load.
- REQ-022 SHALL count rising edges of sclk_in since the last load_in, using a saturating counter of clog2(WIDTH)+1 bits.
- REQ-023 On an le_in rising edge with count != WIDTH, SHALL set misalign.
- REQ-024 load_in together with shift_d in the same cycle: load wins and the shift is discarded.
- REQ-025 load_in SHALL reset the sclk counter to 0.
- REQ-026 Shifting past WIDTH bits SHALL fill with zeros; no wrap-around.
- REQ-027 Each lane SHALL be independent; lanes SHALL be bit-identical in timing.

Reset
- REQ-028 While reset_n is low, SHALL drive the following values, with reset taking effect mid-frame without completing any shift:
  - sdi=0, sclk=0, le=0, oe_n=1 (blank flag set);
  - data_ready=1, underrun=0, misalign=0;
  - staging empty, lane registers 0, counter 0, shift_d=0.

Configuration
- REQ-029 Macro COLUMN_SHIFTER_REPEAT_EN controls underrun behaviour:
  - Defined: an underrun load reloads the lane registers with the last successfully loaded word, and blank is not set.
  - Undefined: an underrun load loads zeros and sets blank.
  - underrun pulses in both builds.

Structure
- REQ-030 Package column_shifter_pkg SHALL hold:
  - LANES/WIDTH default constants;
  - a packed typedef for the 5-bit control bundle (load, shift, sclk, oe_n, le), in that bit order;
  - the counter-width function.
- REQ-031 Sub-module lane_shreg (one WIDTH-bit load/shift register with MSB out) SHALL be instantiated LANES times via generate.

Verification
- REQ-032 Nominal frame:
  - Stimulus: stage lane0=16'hA5C3, all other lanes 0; drive the 64-step control sequence (load at step 0, 15 shift+sclk pulses, a 16th sclk, le at step 50).
  - Required response: sdi[0] sampled at the 16 sclk rises = 1010_0101_1100_0011; misalign=0.
- REQ-033 Underrun:
  - Stimulus: load with staging empty.
  - Required response without the macro: underrun pulses, sdi all 0 for the frame, oe_n=1 until the next good load.
  - Required response with the macro: the previous word is repeated and oe_n follows oe_n_in.
- REQ-034 Simultaneous events:
  - Stimulus 1: data_valid with load_in while staging is full.
    - Required response: old word reaches the lane registers and the new word is staged, with no loss.
  - Stimulus 2: load_in with shift_d.
    - Required response: the lane registers equal the staged word unshifted.
- REQ-035 Misalignment:
  - Stimulus: frame with only 15 sclk pulses before le.
  - Required response: misalign set and stays set through later good frames.
- REQ-036 Reset mid-frame:
  - Stimulus: assert reset_n low at step 20.
  - Required response: all outputs at reset values asynchronously, staging empty; the next frame after a staged word shifts correctly.
- REQ-037 Backpressure:
  - Stimulus: hold data_valid high with no loads.
  - Required response: exactly one word accepted and data_ready low until the next load_in.
